// File: rtl/fractal_pixel_source.sv
// Raster-scan Mandelbrot pixel source: one escape-time iteration per cycle,
// iteration count mapped to RGB, presented with valid/sof/eol under a ready handshake.
// Optional Julia mode when FRACTAL_JULIA_EN is defined (adds julia_re/julia_im inputs).
module fractal_pixel_source #(
  parameter int unsigned WIDTH    = 640,
  parameter int unsigned HEIGHT   = 480,
  parameter int unsigned MAX_ITER = 255,
  parameter int unsigned FRAC     = 12
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [15:0] x_origin,
  input  logic [15:0] y_origin,
  input  logic [15:0] step,
`ifdef FRACTAL_JULIA_EN
  input  logic [15:0] julia_re,
  input  logic [15:0] julia_im,
`endif
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        valid,
  output logic        sof,
  output logic        eol,
  input  logic        ready
);

  localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [7:0] ITER_MAX = 8'(MAX_ITER);
  localparam logic signed [32:0] ESC_LIM = 33'(4) << (2 * FRAC);

  typedef enum logic [1:0] {ST_INIT, ST_ITER, ST_HOLD} state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [7:0]         iter_q, iter_d;
  logic               first_frame_q, first_frame_d;
  logic signed [15:0] xo_q, xo_d, yo_q, yo_d;
  logic [15:0]        step_q, step_d;
  logic signed [15:0] cur_re_q, cur_re_d, cur_im_q, cur_im_d;
  logic signed [15:0] z_re_q, z_re_d, z_im_q, z_im_d;
  logic [7:0]         r_q, r_d, g_q, g_d, b_q, b_d;
  logic               valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
`ifdef FRACTAL_JULIA_EN
  logic signed [15:0] jre_q, jre_d, jim_q, jim_d;
`endif

  logic signed [31:0] rr, ii, ri;
  logic signed [32:0] mag;
  logic signed [15:0] add_re, add_im;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    iter_d        = iter_q;
    first_frame_d = first_frame_q;
    xo_d          = xo_q;
    yo_d          = yo_q;
    step_d        = step_q;
    cur_re_d      = cur_re_q;
    cur_im_d      = cur_im_q;
    z_re_d        = z_re_q;
    z_im_d        = z_im_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    valid_d       = valid_q;
    sof_d         = sof_q;
    eol_d         = eol_q;
`ifdef FRACTAL_JULIA_EN
    jre_d         = jre_q;
    jim_d         = jim_q;
    add_re        = jre_q;
    add_im        = jim_q;
`else
    add_re        = cur_re_q;
    add_im        = cur_im_q;
`endif

    rr  = 32'(z_re_q) * 32'(z_re_q);
    ii  = 32'(z_im_q) * 32'(z_im_q);
    ri  = 32'(z_re_q) * 32'(z_im_q);
    mag = 33'(rr) + 33'(ii);

    case (state_q)
      ST_INIT: begin
        if (enable) begin
          // frame start: capture configuration and restart coordinates
          if (first_frame_q || (x_q == '0 && y_q == '0)) begin
            first_frame_d = 1'b0;
            xo_d          = x_origin;
            yo_d          = y_origin;
            step_d        = step;
            cur_re_d      = x_origin;
            cur_im_d      = y_origin;
`ifdef FRACTAL_JULIA_EN
            jre_d         = julia_re;
            jim_d         = julia_im;
`endif
          end
`ifdef FRACTAL_JULIA_EN
          z_re_d = cur_re_d;
          z_im_d = cur_im_d;
`else
          z_re_d = '0;
          z_im_d = '0;
`endif
          iter_d  = '0;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        if (mag > ESC_LIM || iter_q == ITER_MAX) begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
          sof_d   = (x_q == '0) && (y_q == '0);
          eol_d   = (x_q == X_LAST);
          if (iter_q == ITER_MAX) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
          end else begin
            r_d = {iter_q[4:0], 3'b000};
            g_d = {iter_q[6:0], 1'b0};
            b_d = ~iter_q;
          end
        end else begin
          z_re_d = 16'((rr - ii) >>> FRAC) + add_re;
          z_im_d = 16'(ri >>> (FRAC - 1)) + add_im;
          iter_d = iter_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (ready) begin
          valid_d = 1'b0;
          sof_d   = 1'b0;
          eol_d   = 1'b0;
          state_d = ST_INIT;
          // advance the raster; a wrapped frame relatches config in INIT
          if (x_q != X_LAST) begin
            x_d      = x_q + XW'(1);
            cur_re_d = cur_re_q + $signed(step_q);
          end else begin
            x_d      = '0;
            cur_re_d = xo_q;
            if (y_q != Y_LAST) begin
              y_d      = y_q + YW'(1);
              cur_im_d = cur_im_q + $signed(step_q);
            end else begin
              y_d      = '0;
              cur_im_d = yo_q;
            end
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_INIT;
      x_q           <= '0;
      y_q           <= '0;
      iter_q        <= '0;
      first_frame_q <= 1'b1;
      xo_q          <= '0;
      yo_q          <= '0;
      step_q        <= '0;
      cur_re_q      <= '0;
      cur_im_q      <= '0;
      z_re_q        <= '0;
      z_im_q        <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
`ifdef FRACTAL_JULIA_EN
      jre_q         <= '0;
      jim_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      iter_q        <= iter_d;
      first_frame_q <= first_frame_d;
      xo_q          <= xo_d;
      yo_q          <= yo_d;
      step_q        <= step_d;
      cur_re_q      <= cur_re_d;
      cur_im_q      <= cur_im_d;
      z_re_q        <= z_re_d;
      z_im_q        <= z_im_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      valid_q       <= valid_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
`ifdef FRACTAL_JULIA_EN
      jre_q         <= jre_d;
      jim_q         <= jim_d;
`endif
    end
  end

  assign r     = r_q;
  assign g     = g_q;
  assign b     = b_q;
  assign valid = valid_q;
  assign sof   = sof_q;
  assign eol   = eol_q;

endmodule
